// File: rtl/len_buf_sched.sv
// len_buf_sched: ping-pong code-length buffer between a length extractor
// (writer) and a tree builder (reader) sharing one single-port memory.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_req/wr_data/wr_last -> wr_gnt       writer handshake
//   rd_bank_vld, rd_cnt                    reader-owned bank status
//   rd_req/rd_addr -> rd_gnt, rd_data_vld/rd_data, rd_release
//   mem_addr/mem_wdata/mem_we/mem_re <- mem_rdata   shared buffer port
//   err               sticky overflow / out-of-range read flag
module len_buf_sched #(
    parameter int BANK_AW = 8,
    parameter int DW      = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_req,
    input  logic [DW-1:0]      wr_data,
    input  logic               wr_last,
    output logic               wr_gnt,
    output logic               rd_bank_vld,
    output logic [BANK_AW:0]   rd_cnt,
    input  logic               rd_req,
    input  logic [BANK_AW-1:0] rd_addr,
    output logic               rd_gnt,
    output logic               rd_data_vld,
    output logic [DW-1:0]      rd_data,
    input  logic               rd_release,
    output logic [BANK_AW:0]   mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic               mem_we,
    output logic               mem_re,
    input  logic [DW-1:0]      mem_rdata,
    output logic               err
);

    typedef enum logic [1:0] {
        B_EMPTY,
        B_FILL,
        B_FULL
    } bank_st_t;

    localparam logic [BANK_AW-1:0] PTR_ONE = 1;
    localparam logic [BANK_AW-1:0] PTR_MAX = '1;
    localparam logic [BANK_AW:0]   CNT_ONE = 1;

    bank_st_t           st_q   [2];
    bank_st_t           st_d   [2];
    logic [BANK_AW:0]   cnt_q  [2];
    logic [BANK_AW:0]   cnt_d  [2];
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [BANK_AW-1:0] wr_ptr_q, wr_ptr_d;
    // 0: writer wins the next contended cycle, 1: reader wins
    logic               prio_rd_q, prio_rd_d;
    logic               err_q, err_d;
    logic               rvld_q;

    logic             bank_vld;
    logic [BANK_AW:0] cur_cnt;
    logic             rd_in_rng;
    logic             wr_elig;
    logic             rd_elig;
    logic             rd_bad;
    logic             wg;
    logic             rg;

    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_ptr_d  = wr_ptr_q;
        prio_rd_d = prio_rd_q;
        err_d     = err_q;
        wg        = 1'b0;
        rg        = 1'b0;

        bank_vld  = (st_q[rd_bank_q] == B_FULL);
        cur_cnt   = cnt_q[rd_bank_q];
        rd_in_rng = ({1'b0, rd_addr} < cur_cnt);
        wr_elig   = wr_req && (st_q[wr_bank_q] != B_FULL);
        rd_elig   = rd_req && bank_vld && rd_in_rng;
        rd_bad    = rd_req && bank_vld && !rd_in_rng;

        if (wr_elig && rd_elig) begin
            wg        = !prio_rd_q;
            rg        = prio_rd_q;
            prio_rd_d = !prio_rd_q;
        end else begin
            wg = wr_elig;
            rg = rd_elig;
        end

        if (wg) begin
            // A full bank closes like a normal last entry, but flags err
            if (wr_last || wr_ptr_q == PTR_MAX) begin
                st_d[wr_bank_q]  = B_FULL;
                cnt_d[wr_bank_q] = {1'b0, wr_ptr_q} + CNT_ONE;
                wr_ptr_d         = '0;
                wr_bank_d        = !wr_bank_q;
                if (!wr_last) begin
                    err_d = 1'b1;
                end
            end else begin
                st_d[wr_bank_q] = B_FILL;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
        end

        if (rd_bad) begin
            err_d = 1'b1;
        end

        // Release only touches the FULL read bank, never the write bank
        if (rd_release && bank_vld) begin
            st_d[rd_bank_q]  = B_EMPTY;
            cnt_d[rd_bank_q] = '0;
            rd_bank_d        = !rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q[0]   <= B_EMPTY;
            st_q[1]   <= B_EMPTY;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_ptr_q  <= '0;
            prio_rd_q <= 1'b0;
            err_q     <= 1'b0;
            rvld_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_ptr_q  <= wr_ptr_d;
            prio_rd_q <= prio_rd_d;
            err_q     <= err_d;
            rvld_q    <= rg;
        end
    end

    // Outputs are forced low while reset is held, even before the first edge
    assign wr_gnt      = wg && !rst;
    assign rd_gnt      = rg && !rst;
    assign mem_we      = wr_gnt;
    assign mem_re      = rd_gnt;
    assign mem_wdata   = wr_gnt ? wr_data : '0;
    assign mem_addr    = wr_gnt ? {wr_bank_q, wr_ptr_q} :
                         rd_gnt ? {rd_bank_q, rd_addr}  : '0;
    assign rd_bank_vld = bank_vld && !rst;
    assign rd_cnt      = rd_bank_vld ? cur_cnt : '0;
    assign rd_data_vld = rvld_q && !rst;
    assign rd_data     = rd_data_vld ? mem_rdata : '0;
    assign err         = err_q && !rst;

endmodule

// File: tb/tb_len_buf_sched.sv
// tb_len_buf_sched: directed + random check of len_buf_sched against a
// table-queue reference model.
module tb_len_buf_sched;

    localparam int AW    = 8;
    localparam int DW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_last = 1'b0;
    logic          wr_gnt;
    logic          rd_bank_vld;
    logic [AW:0]   rd_cnt;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_gnt;
    logic          rd_data_vld;
    logic [DW-1:0] rd_data;
    logic          rd_release = 1'b0;
    logic [AW:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    logic          err;

    always #5 clk = ~clk;

    len_buf_sched #(.BANK_AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_data(wr_data), .wr_last(wr_last),
        .wr_gnt(wr_gnt),
        .rd_bank_vld(rd_bank_vld), .rd_cnt(rd_cnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data_vld(rd_data_vld), .rd_data(rd_data),
        .rd_release(rd_release),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .err(err)
    );

    // Shared single-port buffer with synchronous read
    logic [DW-1:0] mem [0:2*DEPTH-1];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Reference model: completed tables in arrival order, values flattened
    int          full_len[$];
    int unsigned tvals[$];
    int          cur_len;
    int          closed_n;
    int          rel_n;
    bit          w_turn;
    bit          err_m;
    bit          pend;
    int unsigned pend_val;

    int n_chk = 0;
    int n_pass = 0;
    bit last_wg;
    bit obs_wg;
    int unsigned obs_addr;

    task automatic chk(input string tag, input int unsigned obs,
                       input int unsigned exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic mdl_reset();
        full_len.delete();
        tvals.delete();
        cur_len  = 0;
        closed_n = 0;
        rel_n    = 0;
        w_turn   = 1'b1;
        err_m    = 1'b0;
        pend     = 1'b0;
        pend_val = 0;
    endtask

    task automatic step(input bit wq, input int unsigned wd, input bit wl,
                        input bit rq, input int unsigned ra, input bit rel);
        bit rv, wok, rok, bad, eg, erg;
        int unsigned rc, ea, dm;
        wr_req     = wq;
        wr_data    = DW'(wd);
        wr_last    = wl;
        rd_req     = rq;
        rd_addr    = AW'(ra);
        rd_release = rel;
        dm = wd % (1 << DW);
        #1;
        rv  = full_len.size() > 0;
        rc  = rv ? full_len[0] : 0;
        wok = wq && full_len.size() < 2;
        rok = rq && rv && ra < rc;
        bad = rq && rv && ra >= rc;
        if (wok && rok) begin
            eg  = w_turn;
            erg = !w_turn;
        end else begin
            eg  = wok;
            erg = rok;
        end
        ea = eg  ? (closed_n % 2) * DEPTH + cur_len :
             erg ? (rel_n % 2) * DEPTH + ra : 0;
        chk("wr_gnt", wr_gnt, eg);
        chk("rd_gnt", rd_gnt, erg);
        chk("mem_we", mem_we, eg);
        chk("mem_re", mem_re, erg);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, eg ? dm : 0);
        chk("rd_bank_vld", rd_bank_vld, rv);
        chk("rd_cnt", rd_cnt, rc);
        chk("err", err, err_m);
        chk("rd_data_vld", rd_data_vld, pend);
        chk("rd_data", rd_data, pend ? pend_val : 0);
        last_wg  = eg;
        obs_wg   = wr_gnt;
        obs_addr = mem_addr;
        @(posedge clk);
        pend = erg;
        if (erg) pend_val = tvals[ra];
        if (eg) begin
            tvals.push_back(dm);
            cur_len++;
            if (wl || cur_len == DEPTH) begin
                if (!wl) err_m = 1'b1;
                full_len.push_back(cur_len);
                cur_len = 0;
                closed_n++;
            end
        end
        if (wok && rok) w_turn = !w_turn;
        if (bad) err_m = 1'b1;
        if (rel && rv) begin
            repeat (full_len[0]) void'(tvals.pop_front());
            void'(full_len.pop_front());
            rel_n++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b1;
        wr_req     = 1'b1;
        wr_last    = 1'b1;
        rd_req     = 1'b1;
        rd_addr    = '0;
        rd_release = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("rst_wr_gnt", wr_gnt, 0);
            chk("rst_rd_gnt", rd_gnt, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_re", mem_re, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_rd_bank_vld", rd_bank_vld, 0);
            chk("rst_rd_cnt", rd_cnt, 0);
            chk("rst_rd_data_vld", rd_data_vld, 0);
            chk("rst_rd_data", rd_data, 0);
            chk("rst_err", err, 0);
            @(negedge clk);
        end
        rst = 1'b0;
        mdl_reset();
    endtask

    initial begin
        int unsigned d5, wd;
        int pat;
        bit w_pend, w_l;
        int unsigned w_d, ra;
        bit rq, rel;

        for (int i = 0; i < 2 * DEPTH; i++) mem[i] = '0;
        mdl_reset();
        @(negedge clk);
        do_reset(3);

        // Reader idle bank: no grant, no err, release ignored
        step(0, 0, 0, 1, 3, 1);
        #1 chk("r47_novld_err", err, 0);

        // 19-entry table, back-to-back grants
        d5 = 0;
        for (int i = 0; i < 19; i++) begin
            wd = $urandom_range(0, 31);
            if (i == 5) d5 = wd;
            step(1, wd, i == 18, 0, 0, 0);
            chk("r43_addr", obs_addr, i);
        end
        #1;
        chk("r43_vld", rd_bank_vld, 1);
        chk("r43_cnt", rd_cnt, 19);
        step(0, 0, 0, 1, 5, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("r43_data", pend_val, d5);

        // Contention: W,R,W,R
        pat = 0;
        wd = $urandom_range(0, 31);
        for (int i = 0; i < 4; i++) begin
            step(1, wd, 0, 1, i, 0);
            pat = (pat << 1) | int'(obs_wg);
            if (last_wg) wd = $urandom_range(0, 31);
        end
        chk("r45_pattern", pat, 4'b1010);

        // Finish table 2, then table 3 stalls until bank0 is released
        for (int i = 0; i < 3; i++) step(1, i + 7, i == 2, 0, 0, 0);
        step(1, 9, 0, 0, 0, 0);
        chk("r44_stall", obs_wg, 0);
        step(1, 9, 0, 0, 0, 1);
        chk("r44_stall_rel", obs_wg, 0);
        step(1, 9, 0, 0, 0, 0);
        chk("r44_resume_gnt", obs_wg, 1);
        chk("r44_resume_addr", obs_addr, 0);

        // Out-of-range read on bank1 (5 entries)
        step(0, 0, 0, 1, 5, 0);
        #1 chk("r47_oor_err", err, 1);

        // Overflow: 256 entries without wr_last
        do_reset(1);
        for (int i = 0; i < DEPTH; i++) step(1, $urandom, 0, 0, 0, 0);
        #1;
        chk("r46_cnt", rd_cnt, DEPTH);
        chk("r46_err", err, 1);
        step(1, 3, 0, 0, 0, 0);
        chk("r46_next_addr", obs_addr, DEPTH);

        // Reset mid-fill
        do_reset(1);
        for (int i = 0; i < 7; i++) step(1, $urandom, 0, 0, 0, 0);
        do_reset(2);
        step(1, 4, 0, 0, 0, 0);
        chk("r48_addr", obs_addr, 0);
        chk("r48_gnt", obs_wg, 1);
        #1 chk("r48_vld", rd_bank_vld, 0);

        // Random traffic
        do_reset(1);
        w_pend = 0;
        w_d = 0;
        w_l = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!w_pend && $urandom_range(0, 3) != 0) begin
                w_pend = 1;
                w_d = $urandom_range(0, 31);
                w_l = $urandom_range(0, 7) == 0;
            end
            rq = $urandom_range(0, 1);
            if (full_len.size() > 0 && $urandom_range(0, 15) != 0)
                ra = $urandom_range(0, full_len[0] - 1);
            else
                ra = $urandom_range(0, DEPTH - 1);
            rel = $urandom_range(0, 19) == 0;
            step(w_pend, w_d, w_l, rq, ra, rel);
            if (last_wg) w_pend = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/len_buf_sched.md
LEN_BUF_SCHED -- requirements
Module: len_buf_sched

Interface
REQ-001 Parameter BANK_AW, default 8, gives the per-bank address width; each bank holds 2^BANK_AW entries.
REQ-002 Parameter DW, default 5, gives the code-length entry width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 wr_req  input  1  writer (length extractor) has one entry to store this cycle.
REQ-006 wr_data  input  DW  entry value, valid with wr_req.
REQ-007 wr_last  input  1  the entry qualified by wr_req is the final entry of the current table.
REQ-008 wr_gnt  output  1  wr_req accepted this cycle; the writer SHALL hold its request until granted.
REQ-009 rd_bank_vld  output  1  a completed bank is owned by the reader.
REQ-010 rd_cnt  output  BANK_AW+1  number of valid entries in the reader-owned bank; 0 when rd_bank_vld=0.
REQ-011 rd_req  input  1  reader (tree builder) requests entry rd_addr.
REQ-012 rd_addr  input  BANK_AW  entry index within the reader-owned bank.
REQ-013 rd_gnt  output  1  rd_req accepted this cycle.
REQ-014 rd_data_vld  output  1  rd_data is valid; asserts exactly one cycle after rd_gnt.
REQ-015 rd_data  output  DW  read entry; this SHALL be mem_rdata passed through while rd_data_vld=1, else 0.
REQ-016 rd_release  input  1  single-cycle pulse; the reader has finished with its bank.
REQ-017 mem_addr  output  BANK_AW+1  address to the shared single-port buffer, {bank, index}.
REQ-018 mem_wdata  output  DW  write data; this SHALL equal wr_data when mem_we=1, else 0.
REQ-019 mem_we / mem_re  output  1 each  write or read strobe; at most one SHALL be high in any cycle.
REQ-020 mem_rdata  input  DW  synchronous-read data, valid one cycle after mem_re.
REQ-021 err  output  1  sticky flag, set on overflow or on an out-of-range read request.

Function
REQ-022 Each bank b in {0,1} SHALL hold a state: EMPTY, FILL, or FULL, plus a stored count cnt_b (BANK_AW+1 bits).
REQ-023 Pointer wr_bank SHALL select the write bank and rd_bank the read bank; both reset to 0, and each toggles only as defined below.
REQ-024 Writer eligibility: wr_req=1 and bank[wr_bank] is EMPTY or FILL; otherwise wr_gnt=0.
REQ-025 Write access: mem_addr={wr_bank, wr_ptr}; wr_ptr increments on each grant; bank[wr_bank] becomes FILL on the first grant.
REQ-026 On a grant with wr_last=1, the block SHALL set bank[wr_bank]=FULL, cnt=wr_ptr+1, wr_ptr=0, and toggle wr_bank.
REQ-027 On a grant with wr_ptr=2^BANK_AW-1 and wr_last=0, the block SHALL close the bank exactly as in REQ-026, with cnt=2^BANK_AW, and set err.
REQ-028 rd_bank_vld SHALL equal (bank[rd_bank]==FULL), and rd_cnt SHALL equal cnt_rd_bank when valid.
REQ-029 Reader eligibility: rd_req=1, rd_bank_vld=1 and rd_addr<rd_cnt.
REQ-030 A rd_req with rd_bank_vld=1 and rd_addr>=rd_cnt SHALL NOT be granted and SHALL set err.
REQ-031 A rd_req with rd_bank_vld=0 SHALL NOT be granted and SHALL NOT set err.
REQ-032 Read access: mem_addr={rd_bank, rd_addr} and mem_re=1 in the grant cycle; rd_data_vld=1 in the next cycle.
REQ-033 Arbitration, single eligible requester: that requester SHALL be granted and the priority flag SHALL be left unchanged.
REQ-034 Arbitration, both eligible: the side named by the priority flag (reset value: writer) SHALL be granted, and the flag SHALL flip to the other side.
REQ-035 rd_release with rd_bank_vld=1 SHALL set bank[rd_bank]=EMPTY and cnt=0, and toggle rd_bank at the clock edge.
REQ-036 A rd_req in the same cycle as rd_release SHALL still be arbitrated against the pre-release state.
REQ-037 rd_release with rd_bank_vld=0 SHALL be ignored.
REQ-038 A bank released in cycle N SHALL be eligible for writer grants from cycle N+1.
REQ-039 When both banks are FULL, the writer SHALL stall (wr_gnt=0) until a release occurs; no entry is lost.
REQ-040 Throughput: with only one requester active, the block SHALL issue one grant per cycle with no bubbles.

Reset
REQ-041 While rst=1, the block SHALL hold:
- both banks EMPTY and cnt=0;
- wr_bank=0, rd_bank=0, wr_ptr=0;
- priority flag = writer;
- err=0;
- all outputs 0, including rd_data_vld.
REQ-042 Reset applied mid-fill or mid-read SHALL discard all bank contents and ownership; the first post-reset grant SHALL write to address 0.

Verification
REQ-043 Writer sends 19 entries, the last with wr_last -> grants at mem_addr 0..18, then rd_bank_vld=1 and rd_cnt=19; reading index 5 returns the written value one cycle later.
REQ-044 Write 3 tables back-to-back with no release -> bank0 and bank1 become FULL and the third table's first wr_req stalls; rd_release frees bank0 and the writer resumes at mem_addr 0 the next cycle.
REQ-045 wr_req and eligible rd_req held together for 4 cycles -> grants W,R,W,R; mem_we and mem_re are never high together.
REQ-046 256 writes with no wr_last (BANK_AW=8) -> bank0 closes with rd_cnt=256, err=1, and the next write goes to mem_addr 256.
REQ-047 rd_req with rd_addr=rd_cnt -> rd_gnt=0 and err=1; rd_req with rd_bank_vld=0 -> rd_gnt=0 and err unchanged.
REQ-048 rst asserted mid-fill after 7 writes -> all outputs 0 during reset; afterwards the first write goes to mem_addr 0 and rd_bank_vld=0.
